// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared constants, ROM field layout and FSM state type for the
// LDPC syndrome checker.
//   N           codeword length (variable nodes)
//   M           number of parity checks (rows)
//   DC / DV     row weight / column weight of H
//   IDX_W       width of one column index in the H-position ROM
//   ROM_W       H-position ROM word width
//   COL_POS_LSB start of the five packed column indices in a ROM word
//   ROW_POS_LSB start of the column-to-row map (unused by this block)
package ldpc_pkg;

    localparam int unsigned N     = 100;
    localparam int unsigned M     = 80;
    localparam int unsigned DC    = 5;
    localparam int unsigned DV    = 4;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned ROM_W = 72;

    localparam int unsigned COL_POS_LSB = 0;
    localparam int unsigned ROW_POS_LSB = 40;

    // Width needed to address one of the N bits; also the ROM address width
    // and the width of the unsatisfied-check counter (0..80).
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 7;

    localparam int unsigned SLOTS_W = DC * IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ldpc_row_parity.sv
// ldpc_row_parity: combinational parity of one H row.
//   bits    in  N        latched hard-decision word, bit k = variable k
//   idx     in  DC*IDX_W packed column indices of the row
//   parity  out 1        XOR of bits at all in-range indices
//   bad     out 1        at least one index was >= N
module ldpc_row_parity
    import ldpc_pkg::*;
(
    input  logic [N-1:0]       bits,
    input  logic [SLOTS_W-1:0] idx,
    output logic               parity,
    output logic               bad
);

    // Out-of-range indices contribute nothing to the parity and only raise bad.
    always_comb begin
        parity = 1'b0;
        bad    = 1'b0;
        for (int s = 0; s < int'(DC); s++) begin
            if (idx[s*IDX_W +: IDX_W] < IDX_W'(N)) begin
                parity = parity ^ bits[idx[s*IDX_W +: COL_W]];
            end else begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldpc_syndrome_checker.sv
// ldpc_syndrome_checker: computes the M-bit syndrome H*x (mod 2) of an N-bit
// word one row per cycle from the external H-position ROM, and compares it
// against a target syndrome.
//   clk, rst    clock, synchronous active-high reset
//   start       request, accepted only in IDLE
//   bits_in     word to check, sampled on the accepting edge
//   target_syn  expected syndrome, sampled with bits_in
//   rom_addr    H-position ROM row address
//   rom_dout    ROM data, valid one cycle after rom_addr
//   busy        operation in progress
//   done        one-cycle completion pulse
//   syndrome    computed syndrome, bit r = row r
//   syn_match   syndrome == target_syn
//   unsat_cnt   popcount(syndrome ^ target_syn)
//   idx_err     a ROM column index >= N was seen during the run
module ldpc_syndrome_checker
    import ldpc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      bits_in,
    input  logic [M-1:0]      target_syn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_dout,
    output logic              busy,
    output logic              done,
    output logic [M-1:0]      syndrome,
    output logic              syn_match,
    output logic [CNT_W-1:0]  unsat_cnt,
    output logic              idx_err
);

    state_t             state;
    logic [N-1:0]       bits_q;
    logic [M-1:0]       target_q;

    // Row-processing stage runs one cycle behind the address stage.
    logic               proc_valid;
    logic [ADDR_W-1:0]  proc_row;

    logic               row_parity;
    logic               row_bad;
    logic               row_mismatch;
    logic [CNT_W-1:0]   unsat_nxt;

    // The column-to-row map shares the ROM word but is not needed here.
    logic               unused_row_map;
    assign unused_row_map = ^rom_dout[ROM_W-1:ROW_POS_LSB];

    ldpc_row_parity u_row_parity (
        .bits   (bits_q),
        .idx    (rom_dout[COL_POS_LSB +: SLOTS_W]),
        .parity (row_parity),
        .bad    (row_bad)
    );

    // Running unsatisfied count including the row currently being processed.
    always_comb begin
        row_mismatch = 1'b0;
        unsat_nxt    = unsat_cnt;
        if (proc_valid) begin
            row_mismatch = row_parity ^ target_q[proc_row];
            unsat_nxt    = unsat_cnt + CNT_W'(row_mismatch);
        end
    end

    // Control FSM, address stage and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bits_q     <= '0;
            target_q   <= '0;
            proc_valid <= 1'b0;
            proc_row   <= '0;
            rom_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            syndrome   <= '0;
            syn_match  <= 1'b0;
            unsat_cnt  <= '0;
            idx_err    <= 1'b0;
        end else begin
            done       <= 1'b0;
            proc_valid <= 1'b0;

            if (proc_valid) begin
                syndrome[proc_row] <= row_parity;
                unsat_cnt          <= unsat_nxt;
                if (row_bad) begin
                    idx_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        bits_q    <= bits_in;
                        target_q  <= target_syn;
                        syndrome  <= '0;
                        unsat_cnt <= '0;
                        idx_err   <= 1'b0;
                        syn_match <= 1'b0;
                        rom_addr  <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    proc_valid <= 1'b1;
                    proc_row   <= rom_addr;
                    if (rom_addr == ADDR_W'(M - 1)) begin
                        state <= DRAIN;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Last row lands on this edge, so match uses the updated count.
                    syn_match <= (unsat_nxt == '0);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_syndrome_checker.sv
// tb_ldpc_syndrome_checker: table-driven directed test of the syndrome checker
// against a bench ROM where row r holds columns (r+20s) mod 100, s=0..4.
module tb_ldpc_syndrome_checker;
    import ldpc_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [N-1:0]      bits_in;
    logic [M-1:0]      target_syn;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_dout;
    logic              busy;
    logic              done;
    logic [M-1:0]      syndrome;
    logic              syn_match;
    logic [CNT_W-1:0]  unsat_cnt;
    logic              idx_err;

    int errors;
    int checks;

    logic [ROM_W-1:0] rom [128];

    typedef struct {
        logic [N-1:0]     bits;
        logic [M-1:0]     target;
        logic [M-1:0]     exp_syn;
        logic             exp_match;
        logic [CNT_W-1:0] exp_unsat;
        logic             exp_idx_err;
        logic             patch;
    } vec_t;

    vec_t vecs [7];

    ldpc_syndrome_checker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bits_in    (bits_in),
        .target_syn (target_syn),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .busy       (busy),
        .done       (done),
        .syndrome   (syndrome),
        .syn_match  (syn_match),
        .unsat_cnt  (unsat_cnt),
        .idx_err    (idx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency ROM read.
    always @(posedge clk) rom_dout <= rom[rom_addr];

    task automatic build_rom();
        for (int r = 0; r < 128; r++) begin
            rom[r] = '0;
            if (r < int'(M)) begin
                // Junk in the row-map field must be ignored.
                rom[r][71:40] = 32'hDEAD_BEEF ^ 32'(r);
                for (int s = 0; s < 5; s++) begin
                    rom[r][39-8*s -: 8] = 8'((r + 20*s) % 100);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observe cycles S+1..S+83 after the accepting edge S and check timing and results.
    task automatic monitor_run(input vec_t v, input int id);
        int               done_at;
        int               done_n;
        bit               busy_ok;
        bit               addr_ok;
        logic [M-1:0]     syn_d;
        logic             match_d;
        logic [CNT_W-1:0] unsat_d;
        logic             ierr_d;
        logic [M-1:0]     syn_h;
        done_at = -1;
        done_n  = 0;
        busy_ok = 1'b1;
        addr_ok = 1'b1;
        syn_d   = 'x;
        match_d = 1'bx;
        unsat_d = 'x;
        ierr_d  = 1'bx;
        syn_h   = 'x;
        for (int k = 1; k <= 83; k++) begin
            @(negedge clk);
            if (busy !== (k <= 81)) busy_ok = 1'b0;
            if (k <= 80 && rom_addr !== ADDR_W'(k - 1)) addr_ok = 1'b0;
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k == 82) begin
                syn_d   = syndrome;
                match_d = syn_match;
                unsat_d = unsat_cnt;
                ierr_d  = idx_err;
            end
            if (k == 83) syn_h = syndrome;
        end
        chk($sformatf("v%0d done_cycle", id), M'(done_at), M'(82));
        chk($sformatf("v%0d done_count", id), M'(done_n), M'(1));
        chk($sformatf("v%0d busy_window", id), M'(busy_ok), M'(1));
        chk($sformatf("v%0d rom_addr_seq", id), M'(addr_ok), M'(1));
        chk($sformatf("v%0d syndrome", id), syn_d, v.exp_syn);
        chk($sformatf("v%0d syn_match", id), M'(match_d), M'(v.exp_match));
        chk($sformatf("v%0d unsat_cnt", id), M'(unsat_d), M'(v.exp_unsat));
        chk($sformatf("v%0d idx_err", id), M'(ierr_d), M'(v.exp_idx_err));
        chk($sformatf("v%0d syndrome_hold", id), syn_h, v.exp_syn);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        if (v.patch) rom[5][23:16] = 8'd120;
        @(negedge clk);
        start      = 1'b1;
        bits_in    = v.bits;
        target_syn = v.target;
        @(posedge clk);
        #1;
        start      = 1'b0;
        bits_in    = '0;
        target_syn = '0;
        monitor_run(v, id);
        if (v.patch) build_rom();
    endtask

    initial begin
        logic [M-1:0] syn1;
        logic [M-1:0] syn99;
        logic [M-1:0] syn_patch;
        logic [M-1:0] flip7;
        vec_t         vr;
        bit           rst_done_seen;

        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        bits_in    = '0;
        target_syn = '0;
        build_rom();

        syn1 = '0;
        syn1[0] = 1'b1; syn1[20] = 1'b1; syn1[40] = 1'b1; syn1[60] = 1'b1;
        // Column 99 appears in rows 19, 39, 59, 79.
        syn99 = '0;
        syn99[19] = 1'b1; syn99[39] = 1'b1; syn99[59] = 1'b1; syn99[79] = 1'b1;
        syn_patch = '1;
        syn_patch[5] = 1'b0;
        flip7 = '0;
        flip7[7] = 1'b1;

        vecs[0] = '{'0,   '0,           '0,        1'b1, 7'd0,  1'b0, 1'b0};
        vecs[1] = '{100'd1, '0,         syn1,      1'b0, 7'd4,  1'b0, 1'b0};
        vecs[2] = '{'1,   '0,           '1,        1'b0, 7'd80, 1'b0, 1'b0};
        vecs[3] = '{100'd1, syn1,       syn1,      1'b1, 7'd0,  1'b0, 1'b0};
        vecs[4] = '{100'd1, syn1 ^ flip7, syn1,    1'b0, 7'd1,  1'b0, 1'b0};
        vecs[5] = '{'1,   '0,           syn_patch, 1'b0, 7'd79, 1'b1, 1'b1};
        vecs[6] = '{100'd1 << 99, '1,   syn99,     1'b0, 7'd76, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", M'(busy), M'(0));
        chk("reset done", M'(done), M'(0));
        chk("reset rom_addr", M'(rom_addr), M'(0));
        chk("reset syndrome", syndrome, '0);
        chk("reset syn_match", M'(syn_match), M'(0));
        chk("reset unsat_cnt", M'(unsat_cnt), M'(0));
        chk("reset idx_err", M'(idx_err), M'(0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Start held high; reset pulsed in cycle S+40 aborts the run.
        @(negedge clk);
        start      = 1'b1;
        bits_in    = '1;
        target_syn = '0;
        @(posedge clk);
        rst_done_seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) rst_done_seen = 1'b1;
        end
        rst     = 1'b1;
        bits_in = 100'd1;
        @(negedge clk);
        if (done === 1'b1) rst_done_seen = 1'b1;
        chk("abort busy", M'(busy), M'(0));
        chk("abort done", M'(rst_done_seen), M'(0));
        chk("abort rom_addr", M'(rom_addr), M'(0));
        chk("abort syndrome", syndrome, '0);
        chk("abort unsat_cnt", M'(unsat_cnt), M'(0));
        chk("abort idx_err", M'(idx_err), M'(0));
        chk("abort syn_match", M'(syn_match), M'(0));
        rst = 1'b0;
        @(posedge clk);
        vr = vecs[1];
        monitor_run(vr, 7);
        start   = 1'b0;
        bits_in = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
